router_fsm: RTL

- Packet-sequencing controller for the 1x3 router.
- Sits between the byte-serial input interface and the router's register and synchroniser stages.
- Decodes each packet header, waits for the addressed output FIFO, sequences payload, parity and FIFO-full handling, and returns to idle on the destination channel's soft reset.
- Drives the `detect_add`/`write_enb_reg` pair consumed by the synchroniser, plus the load-phase strobes consumed by the register block.

---
 rtl/router_fsm.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/router_fsm.sv
// router_fsm: packet-sequencing controller for the 1x3 router.
//
// Decodes each packet header, waits for the addressed output FIFO to drain,
// then sequences header, payload, parity and FIFO-full stalls. It returns
// to DECODE_ADDRESS when the packet ends, when the addressed channel's soft
// reset fires, or when the packet is dropped.
//
// Input handshake: the source presents a byte while pkt_valid=1 and must
// hold that byte unchanged in every cycle where busy=1. pkt_valid falls
// together with the parity byte.
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   pkt_valid, data_in      byte-valid strobe and header address bits
//   fifo_full               full flag of the currently addressed FIFO
//   fifo_empty_0..2         empty flags of output FIFOs 0..2
//   soft_reset_0..2         per-channel time-out resets
//   parity_done             parity byte captured by the register block
//   low_pkt_valid           pkt_valid fell while the FIFO was full
//   detect_add, lfd_state, ld_state, laf_state, full_state,
//   write_enb_reg, rst_int_reg, busy
//                           Moore decode of the current state
//   drop_pkt                one-cycle registered pulse on packet discard
//   dbg_state, dbg_addr     current state encoding and latched address
module router_fsm #(
  parameter int unsigned WAIT_LIMIT = 0,
  parameter int unsigned WAIT_CNT_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pkt_valid,
  input  logic [1:0]            data_in,
  input  logic                  fifo_full,
  input  logic                  fifo_empty_0,
  input  logic                  fifo_empty_1,
  input  logic                  fifo_empty_2,
  input  logic                  soft_reset_0,
  input  logic                  soft_reset_1,
  input  logic                  soft_reset_2,
  input  logic                  parity_done,
  input  logic                  low_pkt_valid,
  output logic                  detect_add,
  output logic                  lfd_state,
  output logic                  ld_state,
  output logic                  laf_state,
  output logic                  full_state,
  output logic                  write_enb_reg,
  output logic                  rst_int_reg,
  output logic                  busy,
  output logic                  drop_pkt,
  output logic [2:0]            dbg_state,
  output logic [1:0]            dbg_addr
);

  typedef enum logic [2:0] {
    DA  = 3'd0,
    LFD = 3'd1,
    LD  = 3'd2,
    FFS = 3'd3,
    LAF = 3'd4,
    LP  = 3'd5,
    CPE = 3'd6,
    WTE = 3'd7
  } state_t;

  localparam logic [WAIT_CNT_W-1:0] LIM_M1 =
    (WAIT_LIMIT == 0) ? '0 : WAIT_CNT_W'(WAIT_LIMIT - 1);
  localparam logic [WAIT_CNT_W-1:0] CNT_MAX = '1;

  state_t                state_q, state_d;
  logic [1:0]            addr_q, addr_d;
  logic                  drop_q, drop_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q;

  // Padded to four entries so the 2-bit address indexes them exactly;
  // address 3 is never a real channel.
  logic [3:0] empty_v;
  logic [3:0] soft_v;
  assign empty_v = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign soft_v  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= DA;
      addr_q  <= 2'd0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
    end
  end

  // Held at zero outside WTE, so it is zero on entry; saturates rather
  // than wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else if (state_q != WTE) begin
      wait_cnt_q <= '0;
    end else if (wait_cnt_q != CNT_MAX) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drop_d  = 1'b0;
    // The addressed channel's soft reset overrides everything except DA.
    if (state_q != DA && soft_v[addr_q]) begin
      state_d = DA;
    end else begin
      case (state_q)
        DA: begin
          if (pkt_valid) begin
            if (data_in == 2'd3) begin
              drop_d = 1'b1;
            end else begin
              addr_d  = data_in;
              state_d = empty_v[data_in] ? LFD : WTE;
            end
          end
        end
        WTE: begin
          if (empty_v[addr_q]) begin
            state_d = LFD;
          end else if (WAIT_LIMIT != 0 && wait_cnt_q == LIM_M1) begin
            state_d = DA;
            drop_d  = 1'b1;
          end
        end
        LFD: state_d = LD;
        LD: begin
          // A stall takes precedence over end-of-packet.
          if (fifo_full)       state_d = FFS;
          else if (!pkt_valid) state_d = LP;
        end
        FFS: begin
          if (!fifo_full) state_d = LAF;
        end
        LAF: begin
          if (parity_done)        state_d = DA;
          else if (low_pkt_valid) state_d = LP;
          else                    state_d = LD;
        end
        LP:  state_d = CPE;
        CPE: state_d = fifo_full ? FFS : DA;
        default: state_d = DA;
      endcase
    end
  end

  assign detect_add    = (state_q == DA);
  assign lfd_state     = (state_q == LFD);
  assign ld_state      = (state_q == LD);
  assign laf_state     = (state_q == LAF);
  assign full_state    = (state_q == FFS);
  assign write_enb_reg = (state_q == LD) || (state_q == LAF) || (state_q == LP);
  assign rst_int_reg   = (state_q == CPE);
  assign busy          = (state_q == LFD) || (state_q == FFS) || (state_q == LAF) ||
                         (state_q == LP)  || (state_q == CPE) || (state_q == WTE);
  assign drop_pkt      = drop_q;
  assign dbg_state     = state_q;
  assign dbg_addr      = addr_q;

endmodule
